// File: rtl/servo_cmd_scheduler_if.sv
// Instruction handshake between the serial instruction receiver (master)
// and the servo command scheduler (slave).
interface servo_cmd_scheduler_if;
    logic       instr_valid;
    logic       instr_ready;
    logic [9:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/servo_cmd_scheduler.sv
// Servo command scheduler: queues 10-bit instructions ({opcode, position})
// and runs them one at a time on the turntable or track servo driver, holding
// each command for a settle period so back-to-back instructions are kept.
// Optional macro LIMIT_SWITCH_EN: track commands finish on the limit switches
// with a timeout that raises a sticky fault; undefined, every command uses
// the settle period and fault stays 0.
module servo_cmd_scheduler #(
    parameter int FIFO_DEPTH     = 4,
    parameter int SETTLE_CYCLES  = 1500000,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic                        clk,
    input  logic                        reset,
    servo_cmd_scheduler_if.slave        instr_bus,
    input  logic                        stop,
    input  logic                        fault_clear,
    input  logic                        extended,
    input  logic                        retracted,
    output logic                        turntable_enable,
    output logic [7:0]                  turntable_position,
    output logic                        track_enable,
    output logic [7:0]                  track_position,
    output logic                        busy,
    output logic                        cmd_done,
    output logic                        fault,
    output logic [$clog2(FIFO_DEPTH):0] queue_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_TURN = 2'b01;
    localparam logic [1:0] OP_EXT  = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    typedef enum logic [1:0] {IDLE, LOAD, MOVE} state_t;

    state_t        state, state_next;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [1:0]    cmd_op;
    logic [7:0]    cmd_pos;
    logic [31:0]   cnt;
    logic          full, empty, push, pop, move_done, timeout, fault_q;

    assign full                  = (count == CW'(FIFO_DEPTH));
    assign empty                 = (count == '0);
    assign instr_bus.instr_ready = !full && !stop && !fault_q;
    assign push                  = instr_bus.instr_valid && instr_bus.instr_ready;
    assign busy                  = (state != IDLE) || !empty;
    assign queue_count           = count;
    assign fault                 = fault_q;

    // Next-state decode: pop in IDLE, decode in LOAD, settle/switch wait in MOVE; stop overrides all.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        move_done  = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !fault_q) begin
                    pop        = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: state_next = (cmd_op == OP_NOP) ? IDLE : MOVE;
            MOVE: begin
`ifdef LIMIT_SWITCH_EN
                if (cmd_op == OP_EXT || cmd_op == OP_RET) begin
                    if ((cmd_op == OP_EXT) ? extended : retracted)
                        move_done = 1'b1;
                    else if (cnt >= 32'(TIMEOUT_CYCLES - 1))
                        timeout = 1'b1;
                end else if (cnt >= SETTLE_LAST) begin
                    move_done = 1'b1;
                end
`else
                if (cnt >= SETTLE_LAST)
                    move_done = 1'b1;
`endif
                if (move_done || timeout)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (stop) begin
            state_next = IDLE;
            pop        = 1'b0;
            move_done  = 1'b0;
            timeout    = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Queue storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= instr_bus.instr;
    end

    // Queue pointers and occupancy; stop and reset both flush.
    always_ff @(posedge clk) begin
        if (reset || stop) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Command register, saturating hold counter and the registered servo outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_op             <= OP_NOP;
            cmd_pos            <= 8'h00;
            cnt                <= '0;
            turntable_enable   <= 1'b0;
            turntable_position <= 8'h00;
            track_enable       <= 1'b0;
            track_position     <= 8'h00;
            cmd_done           <= 1'b0;
        end else begin
            cmd_done <= move_done;
            if (pop) begin
                cmd_op  <= mem[rd_ptr][9:8];
                cmd_pos <= mem[rd_ptr][7:0];
            end
            if (state == LOAD && state_next == MOVE) begin
                cnt <= '0;
                case (cmd_op)
                    OP_TURN: begin
                        turntable_enable   <= 1'b1;
                        turntable_position <= cmd_pos;
                    end
                    OP_EXT: begin
                        track_enable   <= 1'b1;
                        track_position <= 8'hFF;
                    end
                    OP_RET: begin
                        track_enable   <= 1'b1;
                        track_position <= 8'h00;
                    end
                    default: ;
                endcase
            end else if (state == MOVE && state_next == MOVE) begin
                if (cnt != '1)
                    cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (state_next != MOVE) begin
                turntable_enable <= 1'b0;
                track_enable     <= 1'b0;
            end
        end
    end

`ifdef LIMIT_SWITCH_EN
    // Sticky timeout fault; a timeout in the same cycle as fault_clear keeps it set.
    always_ff @(posedge clk) begin
        if (reset)
            fault_q <= 1'b0;
        else if (timeout)
            fault_q <= 1'b1;
        else if (fault_clear)
            fault_q <= 1'b0;
    end
`else
    logic unused_inputs;
    assign fault_q       = 1'b0;
    assign unused_inputs = ^{extended, retracted, fault_clear, timeout, (TIMEOUT_CYCLES != 0)};
`endif
endmodule
